// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, D-stage control inputs and F/D outputs.
interface fetch_unit_if;
    logic [31:0] instr;
    logic        stall;
    logic        redirectD;
    logic [31:0] targetD;
    logic        branchD;
    logic        eretD;
    logic [31:0] epc;
    logic        excReq;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [4:0]  excCodeD;
    logic        bdD;

    // Pipeline side: drives memory data and control, observes fetch state.
    modport master (
        output instr, stall, redirectD, targetD, branchD, eretD, epc, excReq,
        input  pcF, instrD, pcD, excCodeD, bdD
    );

    // Fetch unit side.
    modport slave (
        input  instr, stall, redirectD, targetD, branchD, eretD, epc, excReq,
        output pcF, instrD, pcD, excCodeD, bdD
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, checks fetch legality and loads the F/D register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input logic        clk,
    input logic        reset,
    fetch_unit_if.slave bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;

    logic        fetch_bad;
    logic [31:0] instr_f;
    logic [4:0]  code_f;

    // Fetch legality check; memory data is never forwarded for an illegal address.
    always_comb begin
        fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
        instr_f   = fetch_bad ? 32'h0 : bus.instr;
        code_f    = fetch_bad ? EXC_ADEL : EXC_NONE;
    end

    // Next PC and F/D contents: excReq > stall > eretD > redirectD > sequential.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        code_d  = code_q;
        bd_d    = bd_q;
        if (bus.excReq) begin
            pc_d    = HANDLER_PC;
            instr_d = 32'h0;
            pcd_d   = pc_q;   // bubble keeps a valid PC for EPC
            code_d  = EXC_NONE;
            bd_d    = 1'b0;
        end else if (bus.stall) begin
            // hold everything
        end else if (bus.eretD) begin
            // eret has no delay slot: squash the word fetched behind it
            pc_d    = bus.epc;
            instr_d = 32'h0;
            pcd_d   = pc_q;
            code_d  = EXC_NONE;
            bd_d    = 1'b0;
        end else begin
            pc_d    = bus.redirectD ? bus.targetD : pc_q + 32'd4;
            instr_d = instr_f;
            pcd_d   = pc_q;
            code_d  = code_f;
            bd_d    = bus.branchD;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcd_q   <= RESET_PC;
            code_q  <= EXC_NONE;
            bd_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            code_q  <= code_d;
            bd_q    <= bd_d;
        end
    end

    assign bus.pcF      = pc_q;
    assign bus.instrD   = instr_q;
    assign bus.pcD      = pcd_q;
    assign bus.excCodeD = code_q;
    assign bus.bdD      = bd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random control, checked against a cycle model.
module tb_fetch_unit;

    logic clk;
    logic reset;
    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Synthetic instruction memory contents: a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.instr = mem_word(bus.pcF);

    // Reference state
    logic [31:0] m_pc, m_instrD, m_pcD;
    logic [4:0]  m_code;
    logic        m_bd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                        input logic br, input logic er, input logic [31:0] ep, input logic ex);
        logic        legal;
        longint      sum;
        reset         = rst;
        bus.stall     = st;
        bus.redirectD = rd;
        bus.targetD   = tgt;
        bus.branchD   = br;
        bus.eretD     = er;
        bus.epc       = ep;
        bus.excReq    = ex;
        if (rst) begin
            m_pc = 32'h3000; m_instrD = 0; m_pcD = 32'h3000; m_code = 0; m_bd = 0;
        end else if (ex) begin
            m_pcD = m_pc; m_instrD = 0; m_code = 0; m_bd = 0;
            m_pc = 32'h4180;
        end else if (st) begin
            // nothing moves
        end else if (er) begin
            m_pcD = m_pc; m_instrD = 0; m_code = 0; m_bd = 0;
            m_pc = ep;
        end else begin
            legal    = (m_pc % 4 == 0) && (m_pc >= 32'h3000) && (m_pc <= 32'h6FFC);
            m_instrD = legal ? mem_word(m_pc) : 32'h0;
            m_code   = legal ? 5'd0 : 5'd4;
            m_bd     = br;
            m_pcD    = m_pc;
            sum      = longint'(m_pc) + 4;
            m_pc     = rd ? tgt : 32'(sum % 64'h1_0000_0000);
        end
        @(posedge clk);
        #1;
        check_eq("pcF", bus.pcF, m_pc);
        check_eq("instrD", bus.instrD, m_instrD);
        check_eq("pcD", bus.pcD, m_pcD);
        check_eq("excCodeD", {27'h0, bus.excCodeD}, {27'h0, m_code});
        check_eq("bdD", {31'h0, bus.bdD}, {31'h0, m_bd});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
    endfunction

    initial begin
        logic [31:0] held_pc, held_instr, held_pcd;
        reset = 1'b1;
        bus.stall = 0; bus.redirectD = 0; bus.targetD = 0; bus.branchD = 0;
        bus.eretD = 0; bus.epc = 0; bus.excReq = 0;

        // Reset, then sequential fetch
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("reset_pcF", bus.pcF, 32'h3000);
        check_eq("reset_pcD", bus.pcD, 32'h3000);
        idle();
        check_eq("seq_pcF", bus.pcF, 32'h3004);
        check_eq("seq_instrD", bus.instrD, mem_word(32'h3000));
        idle(); idle(); idle();
        check_eq("pre_redirect_pcF", bus.pcF, 32'h3010);

        // Taken branch: delay slot at 3010 passes with bdD, then 3100
        step(1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("redir_pcD", bus.pcD, 32'h3010);
        check_eq("redir_bdD", {31'h0, bus.bdD}, 32'h1);
        check_eq("redir_pcF", bus.pcF, 32'h3100);

        // Stall for 3 cycles holds everything
        held_pc = bus.pcF; held_instr = bus.instrD; held_pcd = bus.pcD;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_pcF", bus.pcF, held_pc);
        check_eq("stall_instrD", bus.instrD, held_instr);
        check_eq("stall_pcD", bus.pcD, held_pcd);
        idle();
        check_eq("resume_pcF", bus.pcF, held_pc + 32'd4);

        // Exception wins over stall
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("exc_pcF", bus.pcF, 32'h4180);
        check_eq("exc_instrD", bus.instrD, 32'h0);

        // eret during stall waits, then returns to EPC and squashes
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3044, 1'b0);
        check_eq("eret_stalled_pcF", bus.pcF, 32'h4180);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3044, 1'b0);
        check_eq("eret_pcF", bus.pcF, 32'h3044);
        check_eq("eret_instrD", bus.instrD, 32'h0);
        idle();
        check_eq("eret_target_instrD", bus.instrD, mem_word(32'h3044));

        // Misaligned and out-of-range redirect targets fault once in D
        step(1'b0, 1'b0, 1'b1, 32'h3002, 1'b1, 1'b0, 32'h0, 1'b0);
        idle();
        check_eq("misal_code", {27'h0, bus.excCodeD}, 32'd4);
        check_eq("misal_pcD", bus.pcD, 32'h3002);
        step(1'b0, 1'b0, 1'b1, 32'h7000, 1'b1, 1'b0, 32'h0, 1'b0);
        idle();
        check_eq("range_code", {27'h0, bus.excCodeD}, 32'd4);
        check_eq("range_instrD", bus.instrD, 32'h0);
        check_eq("range_pcD", bus.pcD, 32'h7000);

        // PC wrap past the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        check_eq("wrap_pcF", bus.pcF, 32'h0);
        idle();
        check_eq("wrap_code", {27'h0, bus.excCodeD}, 32'd4);

        // Randomised control traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 rand_target(),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0,
                 rand_target(),
                 $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
